// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the OBI-to-APB bridge.
package zeroheti_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } obi_apb_state_e;

  localparam int unsigned ObiApbTimeoutDefault = 255;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts consecutive ACCESS cycles; expired_o flags the last allowed cycle.
module apb_timeout_counter #(
  parameter int unsigned Cycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q;

  // Expires during the Cycles-th enabled cycle, so pready in that same cycle still wins.
  assign expired_o = en_i && (cnt_q == CntW'(Cycles - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/obi_apb_bridge.sv
// Single-outstanding OBI to APB bridge. Optional ACCESS timeout: define OBI_APB_TIMEOUT_EN.
module obi_apb_bridge
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = ObiApbTimeoutDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  obi_apb_state_e state_q, state_d;

  logic [AddrWidth-1:0] paddr_q;
  logic                 pwrite_q;
  logic [DataWidth-1:0] pwdata_q;
  logic [StrbWidth-1:0] pstrb_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;
  logic                 timeout;

`ifdef OBI_APB_TIMEOUT_EN
  apb_timeout_counter #(
    .Cycles (TimeoutCycles)
  ) i_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (state_q == ACCESS),
    .clr_i     (state_q != ACCESS),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A grant while reset is asserted would be lost, so hold it off.
        gnt_o = req_i && rst_ni;
        if (gnt_o) state_d = SETUP;
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      if (gnt_o) begin
        paddr_q  <= addr_i;
        pwrite_q <= we_i;
        pwdata_q <= wdata_i;
        pstrb_q  <= we_i ? be_i : '0;
      end
      // pready takes priority over an expiring timeout in the same cycle.
      if (state_q == ACCESS) begin
        if (pready_i) begin
          rvalid_q <= 1'b1;
          err_q    <= pslverr_i;
          rdata_q  <= pwrite_q ? '0 : prdata_i;
        end else if (timeout) begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
        end
      end
    end
  end

  assign paddr_o  = paddr_q;
  assign pwrite_o = pwrite_q;
  assign pwdata_o = pwdata_q;
  assign pstrb_o  = pstrb_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_obi_apb_bridge.sv
// Scoreboard bench for obi_apb_bridge: random OBI traffic against a randomized APB slave.
module tb_obi_apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_i, gnt_o, we_i;
  logic [AW-1:0] addr_i;
  logic [SW-1:0] be_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o, err_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] paddr_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  always #5 clk = ~clk;

  obi_apb_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    int wait_n; logic [31:0] rd; logic err; int g;
  } xfer_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;

  xfer_t sl_q[$];
  rsp_t  exp_q[$];
  int    checks = 0, fails = 0, cyc = 0, last_g = 0;
  xfer_t mx;
  rsp_t  mr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: OBI response scoreboard and APB phase checks.
  always @(negedge clk) if (rst_n) begin
    chk("gnt", gnt_o, req_i && !psel_o);
    if (rvalid_o) begin
      if (exp_q.size() == 0) flag("unexpected_rvalid");
      else begin
        mr = exp_q.pop_front();
        chk("rdata", rdata_o, mr.rdata);
        chk("err", err_o, mr.err);
        chk("rvalid_cycle", cyc, mr.cyc);
      end
    end else begin
      chk("idle_rdata", rdata_o, 0);
      chk("idle_err", err_o, 0);
    end
    if (psel_o) begin
      if (sl_q.size() == 0) flag("unexpected_psel");
      else begin
        mx = sl_q[0];
        chk("paddr", paddr_o, mx.addr);
        chk("pwrite", pwrite_o, mx.we);
        chk("pwdata", pwdata_o, mx.wdata);
        chk("pstrb", pstrb_o, mx.we ? mx.be : 4'h0);
        if (!penable_o) chk("setup_cycle", cyc, mx.g + 1);
      end
    end else begin
      chk("penable_idle", penable_o, 0);
    end
  end

  // APB slave: answers after the planned number of wait states, junk otherwise.
  initial begin
    automatic int  acnt = 0;
    automatic logic was_acc = 1'b0, acc;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      acc = psel_o && penable_o;
      if (was_acc && !acc && sl_q.size() > 0) void'(sl_q.pop_front());
      if (acc) begin
        if (sl_q.size() > 0 && acnt == sl_q[0].wait_n) begin
          pready = 1'b1; prdata = sl_q[0].rd; pslverr = sl_q[0].err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        end
        acnt++;
      end else begin
        acnt = 0; pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
      was_acc = acc;
    end
  end

  task automatic junk_inputs();
    addr_i = $urandom; we_i = 1'($urandom); be_i = 4'($urandom); wdata_i = $urandom;
  endtask

  // Issue one request from posedge+#1; returns at posedge+#1 after the grant.
  task automatic do_req(logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd,
                        int wt, logic [31:0] rd, logic er);
    xfer_t x;
    rsp_t  r;
    int    n = 0;
    req_i = 1'b1; addr_i = a; we_i = we; be_i = be; wdata_i = wd;
    @(negedge clk);
    while (!gnt_o && n < 100) begin n++; @(negedge clk); end
    if (!gnt_o) flag("grant_timeout");
    else begin
      x = '{a, we, be, wd, wt, rd, er, cyc};
      sl_q.push_back(x);
      r = '{we ? 32'h0 : rd, er, cyc + 3 + wt};
`ifdef OBI_APB_TIMEOUT_EN
      if (wt >= TO) r = '{32'h0, 1'b1, cyc + 2 + TO};
`endif
      exp_q.push_back(r);
      last_g = cyc;
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    junk_inputs();
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int g0, g1, n;
    rst_n = 1'b0; req_i = 1'b1; junk_inputs();
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", gnt_o, 0);     chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0); chk("rst_pwrite", pwrite_o, 0);
    chk("rst_paddr", paddr_o, 0); chk("rst_pwdata", pwdata_o, 0);
    chk("rst_pstrb", pstrb_o, 0); chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0); chk("rst_err", err_o, 0);
    req_i = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    do_req(32'h0000_1004, 1'b0, 4'hF, $urandom, 0, 32'hCAFE_F00D, 1'b0);
    idle(4);
    do_req(32'h0000_2000, 1'b1, 4'b0011, 32'h1234_5678, 3, $urandom, 1'b0);
    idle(8);
    do_req(32'h0000_3000, 1'b0, 4'hF, $urandom, 1, 32'hDEAD_BEEF, 1'b1);
    idle(6);

    // Back-to-back, zero wait: grants three cycles apart.
    do_req(32'h100, 1'b0, 4'hF, 0, 0, 32'h11, 1'b0); g0 = last_g;
    do_req(32'h104, 1'b1, 4'h5, 32'h22, 0, 0, 1'b0); g1 = last_g;
    chk("b2b_gap1", g1 - g0, 3);
    do_req(32'h108, 1'b0, 4'hF, 0, 0, 32'h33, 1'b0);
    chk("b2b_gap2", last_g - g1, 3);
    idle(6);

    // Reset in ACCESS aborts the transfer with no response.
    do_req(32'h0000_4000, 1'b0, 4'hF, 0, 6, 32'h4444, 1'b0);
    n = 0;
    while (!(psel_o && penable_o) && n < 20) begin @(posedge clk); #1; n++; end
    if (!(psel_o && penable_o)) flag("access_wait");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_psel", psel_o, 0);
    chk("abort_rvalid", rvalid_o, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    idle(8);
    do_req(32'h0000_5000, 1'b0, 4'hF, 0, 2, 32'hA5A5_5A5A, 1'b0);

    // Random traffic, with short req pulses while the bridge is busy.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) begin
        req_i = psel_o & 1'($urandom);
        junk_inputs();
        @(posedge clk); #1;
      end
      req_i = 1'b0;
      do_req($urandom, 1'($urandom), 4'($urandom), $urandom,
             $urandom_range(0, 6), $urandom, 1'($urandom));
    end

    n = 0;
    while ((exp_q.size() > 0 || sl_q.size() > 0) && n < 200) begin @(posedge clk); #1; n++; end
    if (exp_q.size() > 0 || sl_q.size() > 0) flag("drain_timeout");
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_apb_bridge.md
OBI_APB_BRIDGE -- requirements
Module: obi_apb_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning the address width on both sides.
REQ-002 SHALL have parameter DataWidth, default 32, meaning the data width on both sides (a multiple of 8).
REQ-003 SHALL have parameter TimeoutCycles, default 255, meaning the maximum number of ACCESS cycles before abort (used only with the timeout feature).
REQ-004 SHALL use one clock, clk_i; reset rst_ni SHALL be synchronous and active-low.
REQ-005 Ports, in order:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  AddrWidth  request address
- we_i  in  1  write enable
- be_i  in  DataWidth/8  byte enables
- wdata_i  in  DataWidth  write data
- rvalid_o  out  1  response valid
- rdata_o  out  DataWidth  read data
- err_o  out  1  response error
- paddr_o  out  AddrWidth  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- pwdata_o  out  DataWidth  APB write data
- pstrb_o  out  DataWidth/8  APB strobe
- prdata_i  in  DataWidth  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error

Function
REQ-006 SHALL use an FSM with states IDLE, SETUP and ACCESS.
REQ-007 In IDLE, gnt_o SHALL equal req_i combinationally; gnt_o SHALL be 0 in SETUP and ACCESS, so at most one transfer is outstanding.
REQ-008 On req_i&&gnt_o, SHALL register addr_i, we_i, be_i and wdata_i, then go to SETUP.
REQ-009 SETUP SHALL last exactly 1 cycle with psel_o=1 and penable_o=0, then go to ACCESS.
REQ-010 ACCESS SHALL drive psel_o=1 and penable_o=1, and SHALL hold all APB outputs stable until pready_i=1.
REQ-011 paddr_o, pwrite_o and pwdata_o SHALL come from the registered request; pstrb_o SHALL be the registered be on writes and 0 on reads.
REQ-012 In ACCESS with pready_i=1, SHALL go to IDLE; in the next cycle rvalid_o=1 for exactly 1 cycle, err_o=registered pslverr_i, and rdata_o=registered prdata_i on reads or 0 on writes.
REQ-013 Latency: grant at cycle N, SETUP at N+1, ACCESS at N+2, and with zero wait states rvalid_o at N+3.
REQ-014 A new request SHALL be grantable in the same cycle that rvalid_o is asserted (back-to-back).
REQ-015 psel_o and penable_o SHALL be 0 in IDLE; paddr_o, pwdata_o and pstrb_o SHALL hold their last values in IDLE.
REQ-016 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.
REQ-017 Req_i deassertion before grant SHALL be legal and SHALL have no effect; changes to request inputs after grant SHALL be ignored.

Reset
REQ-018 On rst_ni=0 at a clk_i edge: state=IDLE, and gnt_o, rvalid_o, err_o, psel_o, penable_o, pwrite_o all 0, with paddr_o, pwdata_o, pstrb_o, rdata_o all 0.
REQ-019 Reset during SETUP or ACCESS SHALL abort the transfer: psel_o=0 from the following cycle, and no rvalid_o is ever issued for it.

Configuration
REQ-020 Macro OBI_APB_TIMEOUT_EN defined: an ACCESS cycle counter SHALL run; if it reaches TimeoutCycles without pready_i, the bridge SHALL go to IDLE, drop psel_o/penable_o, and issue rvalid_o next cycle with err_o=1 and rdata_o=0.
REQ-021 pready_i=1 in the same cycle the count is reached SHALL complete normally, with no error from the timeout.
REQ-022 Macro OBI_APB_TIMEOUT_EN undefined: there SHALL be no counter logic, and ACCESS SHALL wait indefinitely for pready_i.

Structure
REQ-023 zeroheti_pkg SHALL hold typedef obi_apb_state_e (IDLE, SETUP, ACCESS) and constant ObiApbTimeoutDefault=255.
REQ-024 The counter SHALL be sub-module apb_timeout_counter (enable, clear, expired output), instantiated only under OBI_APB_TIMEOUT_EN.

Verification
REQ-025 Read, zero-wait: req addr 0x0000_1004, pready_i=1, prdata_i=0xCAFE_F00D -> SETUP at N+1, ACCESS at N+2, rvalid_o at N+3 with rdata_o=0xCAFE_F00D and err_o=0.
REQ-026 Write, 3 wait states: addr 0x0000_2000, wdata 0x1234_5678, be 4'b0011 -> pstrb_o=4'b0011 and APB signals stable for 4 ACCESS cycles; rvalid_o at N+6 with rdata_o=0.
REQ-027 Error: read with pslverr_i=1 at pready_i=1 -> rvalid_o with err_o=1.
REQ-028 Back-to-back: req_i held for 3 transfers, zero-wait -> grants at cycles 0, 3 and 6, with no overlapping psel_o.
REQ-029 Timeout (macro on, TimeoutCycles=4): pready_i held at 0 -> psel_o drops after 4 ACCESS cycles, then rvalid_o=1, err_o=1, rdata_o=0.
REQ-030 Reset in ACCESS: rst_ni=0 for 1 cycle -> psel_o=0 next cycle, no rvalid_o, and a subsequent read completes normally.
